// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: ALU opcodes, MIPS op/funct fields, mux selects, states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    typedef enum logic [3:0] {
        IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT
    } state_t;

    // Instruction class chosen at decode; CL_NOP covers every undecodable encoding.
    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_BEQ, CL_BNE, CL_LW, CL_SW, CL_J, CL_JAL, CL_HALT, CL_NOP
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [2:0] aluop;
        logic       extsel;
        logic       alusrcb;
        logic [1:0] regdst;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the control unit and the datapath: IR fields and ALU flag in, mux selects and enables out.
// Latency: none (wires only).
// Backpressure: none; the datapath accepts every enable in the cycle it is issued.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] ALUopcode;
    logic       ALUSrcB;
    logic       ExtSel;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       MemRd;
    logic       MemWr;
    logic       illegal;
    logic       halted;

    modport master (
        input  op, funct, zero,
        output ALUopcode, ALUSrcB, ExtSel, PCWre, PCSrc, IRWre, RegWre,
               RegDst, WrRegDSrc, DBDataSrc, MemRd, MemWr, illegal, halted
    );

    modport slave (
        output op, funct, zero,
        input  ALUopcode, ALUSrcB, ExtSel, PCWre, PCSrc, IRWre, RegWre,
               RegDst, WrRegDSrc, DBDataSrc, MemRd, MemWr, illegal, halted
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Instruction decoder: maps op/funct to class, ALU opcode, extension mode, operand B select and destination.
// Latency: purely combinational.
// Backpressure: none.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Anything not matched below stays an illegal NOP.
    always_comb begin
        dec.cls     = CL_NOP;
        dec.aluop   = ALU_ADD;
        dec.extsel  = 1'b0;
        dec.alusrcb = 1'b0;
        dec.regdst  = RD_RT;
        dec.illegal = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec.cls     = CL_RTYPE;
                dec.regdst  = RD_RD;
                dec.illegal = 1'b0;
                case (funct)
                    F_ADD:   dec.aluop = ALU_ADD;
                    F_SUB:   dec.aluop = ALU_SUB;
                    F_AND:   dec.aluop = ALU_AND;
                    F_OR:    dec.aluop = ALU_OR;
                    F_SLT:   dec.aluop = ALU_SLT;
                    F_SLTU:  dec.aluop = ALU_SLTU;
                    default: begin
                        dec.cls     = CL_NOP;
                        dec.regdst  = RD_RT;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                dec.cls = CL_IMM; dec.aluop = ALU_ADD; dec.extsel = 1'b1;
                dec.alusrcb = 1'b1; dec.illegal = 1'b0;
            end
            OP_ORI: begin
                dec.cls = CL_IMM; dec.aluop = ALU_OR; dec.extsel = 1'b0;
                dec.alusrcb = 1'b1; dec.illegal = 1'b0;
            end
            OP_SLTI: begin
                dec.cls = CL_IMM; dec.aluop = ALU_SLT; dec.extsel = 1'b1;
                dec.alusrcb = 1'b1; dec.illegal = 1'b0;
            end
            OP_LW: begin
                dec.cls = CL_LW; dec.extsel = 1'b1; dec.alusrcb = 1'b1; dec.illegal = 1'b0;
            end
            OP_SW: begin
                dec.cls = CL_SW; dec.extsel = 1'b1; dec.alusrcb = 1'b1; dec.illegal = 1'b0;
            end
            OP_BEQ: begin
                dec.cls = CL_BEQ; dec.aluop = ALU_SUB; dec.extsel = 1'b1; dec.illegal = 1'b0;
            end
            OP_BNE: begin
                dec.cls = CL_BNE; dec.aluop = ALU_SUB; dec.extsel = 1'b1; dec.illegal = 1'b0;
            end
            OP_J:    begin dec.cls = CL_J;    dec.illegal = 1'b0; end
            OP_JAL:  begin dec.cls = CL_JAL;  dec.regdst = RD_RA; dec.illegal = 1'b0; end
            OP_HALT: begin dec.cls = CL_HALT; dec.illegal = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives ALU opcode, selects and datapath enables.
// Latency: 2 cycles for j/jal/illegal, 3 for branches, 4 for ALU ops and sw, 5 for lw.
// Backpressure: none; only reset leaves HALT, and reset aborts any instruction in flight.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic                CLK,
    input  logic                Reset,
    multicycle_ctrl_if.master   bus
);

    state_t     state, state_nxt;
    dec_t       dec;
    iclass_t    cls_q;
    logic [2:0] aluop_q;
    logic       extsel_q;
    logic       alusrcb_q;
    logic [1:0] regdst_q;

    ctrl_decode u_decode (
        .op    (bus.op),
        .funct (bus.funct),
        .dec   (dec)
    );

    // State register; reset returns to fetch immediately.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= IF;
        else        state <= state_nxt;
    end

    // Decode results are captured at the end of ID so later IR changes are ignored.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cls_q     <= CL_NOP;
            aluop_q   <= ALU_ADD;
            extsel_q  <= 1'b0;
            alusrcb_q <= 1'b0;
            regdst_q  <= RD_RT;
        end else if (state == ID) begin
            cls_q     <= dec.cls;
            aluop_q   <= dec.aluop;
            extsel_q  <= dec.extsel;
            alusrcb_q <= dec.alusrcb;
            regdst_q  <= dec.regdst;
        end
    end

    // Next-state selection; ID dispatches on the live decode, MEM on the registered class.
    always_comb begin
        state_nxt = IF;
        case (state)
            IF:     state_nxt = ID;
            ID: begin
                case (dec.cls)
                    CL_RTYPE, CL_IMM: state_nxt = EXE_AL;
                    CL_BEQ, CL_BNE:   state_nxt = EXE_BR;
                    CL_LW, CL_SW:     state_nxt = EXE_LS;
                    CL_HALT:          state_nxt = HALT;
                    default:          state_nxt = IF;
                endcase
            end
            EXE_AL: state_nxt = WB_AL;
            WB_AL:  state_nxt = IF;
            EXE_BR: state_nxt = IF;
            EXE_LS: state_nxt = MEM;
            MEM:    state_nxt = (cls_q == CL_LW) ? WB_LD : IF;
            WB_LD:  state_nxt = IF;
            HALT:   state_nxt = HALT;
            default: state_nxt = IF;
        endcase
    end

    // Output decode per state; reset low masks every output so no write escapes an abort.
    always_comb begin
        bus.ALUopcode = ALU_ADD;
        bus.ALUSrcB   = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.PCWre     = 1'b0;
        bus.PCSrc     = PC_PLUS4;
        bus.IRWre     = 1'b0;
        bus.RegWre    = 1'b0;
        bus.RegDst    = RD_RT;
        bus.WrRegDSrc = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.MemRd     = 1'b0;
        bus.MemWr     = 1'b0;
        bus.illegal   = 1'b0;
        bus.halted    = 1'b0;
        if (Reset) begin
            case (state)
                IF: bus.IRWre = 1'b1;
                ID: begin
                    case (dec.cls)
                        CL_J: begin
                            bus.PCWre = 1'b1;
                            bus.PCSrc = PC_JUMP;
                        end
                        CL_JAL: begin
                            bus.PCWre     = 1'b1;
                            bus.PCSrc     = PC_JUMP;
                            bus.RegWre    = 1'b1;
                            bus.RegDst    = RD_RA;
                            bus.WrRegDSrc = 1'b1;
                        end
                        CL_NOP: begin
                            bus.illegal = dec.illegal;
                            bus.PCWre   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                EXE_AL, WB_AL: begin
                    bus.ALUopcode = aluop_q;
                    bus.ALUSrcB   = alusrcb_q;
                    bus.ExtSel    = extsel_q;
                    if (state == WB_AL) begin
                        bus.RegWre = 1'b1;
                        bus.RegDst = regdst_q;
                        bus.PCWre  = 1'b1;
                    end
                end
                EXE_BR: begin
                    bus.ALUopcode = ALU_SUB;
                    bus.PCWre     = 1'b1;
                    if (((cls_q == CL_BEQ) && bus.zero) || ((cls_q == CL_BNE) && !bus.zero))
                        bus.PCSrc = PC_BRANCH;
                end
                EXE_LS, MEM: begin
                    bus.ALUopcode = ALU_ADD;
                    bus.ALUSrcB   = 1'b1;
                    bus.ExtSel    = 1'b1;
                    if (state == MEM) begin
                        if (cls_q == CL_LW) begin
                            bus.MemRd = 1'b1;
                        end else begin
                            bus.MemWr = 1'b1;
                            bus.PCWre = 1'b1;
                        end
                    end
                end
                WB_LD: begin
                    bus.RegWre    = 1'b1;
                    bus.DBDataSrc = 1'b1;
                    bus.PCWre     = 1'b1;
                end
                HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions against a per-instruction cycle model.
// Latency: each instruction is checked cycle by cycle from its IF to the next IF.
// Backpressure: not applicable.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alusrcb;
        logic       extsel;
        logic       pcwre;
        logic [1:0] pcsrc;
        logic       irwre;
        logic       regwre;
        logic [1:0] regdst;
        logic       wrregdsrc;
        logic       dbdatasrc;
        logic       memrd;
        logic       memwr;
        logic       illegal;
        logic       halted;
    } outs_t;

    localparam int K_R = 0, K_I = 1, K_BEQ = 2, K_BNE = 3, K_LW = 4, K_SW = 5;
    localparam int K_J = 6, K_JAL = 7, K_HALT = 8, K_ILL = 9;

    logic  CLK;
    logic  Reset;
    int    checks   = 0;
    int    failures = 0;
    outs_t obs;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign obs = {bus.ALUopcode, bus.ALUSrcB, bus.ExtSel, bus.PCWre, bus.PCSrc, bus.IRWre,
                  bus.RegWre, bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc, bus.MemRd, bus.MemWr,
                  bus.illegal, bus.halted};

    // Instruction kind from the MIPS encoding table.
    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                         6'b101010, 6'b101011}) ? K_R : K_ILL;
            6'b001000, 6'b001101, 6'b001010: return K_I;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b111111: return K_HALT;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b001101) return 3'b011;
        if (o == 6'b001010) return 3'b101;
        if (o != 6'b000000) return 3'b000;
        case (f)
            6'b100010: return 3'b001;
            6'b100100: return 3'b010;
            6'b100101: return 3'b011;
            6'b101010: return 3'b101;
            6'b101011: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    // Cycles from IF to next IF; halt is observed for 20 cycles after it is entered.
    function automatic int ins_len(input int kd);
        case (kd)
            K_R, K_I, K_SW:    return 4;
            K_BEQ, K_BNE:      return 3;
            K_LW:              return 5;
            K_HALT:            return 22;
            default:           return 2;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is its fetch).
    function automatic outs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
        outs_t e;
        int    kd;
        e  = '0;
        kd = kind_of(o, f);
        if (k == 0) begin
            e.irwre = 1'b1;
            return e;
        end
        case (kd)
            K_J: if (k == 1) begin e.pcwre = 1'b1; e.pcsrc = 2'b10; end
            K_JAL: if (k == 1) begin
                e.pcwre = 1'b1; e.pcsrc = 2'b10; e.regwre = 1'b1;
                e.regdst = 2'b10; e.wrregdsrc = 1'b1;
            end
            K_ILL: if (k == 1) begin e.illegal = 1'b1; e.pcwre = 1'b1; end
            K_HALT: if (k >= 2) e.halted = 1'b1;
            K_R, K_I: if (k >= 2) begin
                e.aluop   = alu_of(o, f);
                e.alusrcb = (kd == K_I);
                e.extsel  = (kd == K_I) && (o != 6'b001101);
                if (k == 3) begin
                    e.regwre = 1'b1;
                    e.regdst = (kd == K_R) ? 2'b01 : 2'b00;
                    e.pcwre  = 1'b1;
                end
            end
            K_BEQ, K_BNE: if (k == 2) begin
                e.aluop = 3'b001;
                e.pcwre = 1'b1;
                e.pcsrc = (((kd == K_BEQ) && z) || ((kd == K_BNE) && !z)) ? 2'b01 : 2'b00;
            end
            K_LW, K_SW: begin
                if (k == 2 || k == 3) begin
                    e.aluop = 3'b000; e.alusrcb = 1'b1; e.extsel = 1'b1;
                end
                if (k == 3 && kd == K_LW) e.memrd = 1'b1;
                if (k == 3 && kd == K_SW) begin e.memwr = 1'b1; e.pcwre = 1'b1; end
                if (k == 4) begin e.regwre = 1'b1; e.dbdatasrc = 1'b1; e.pcwre = 1'b1; end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        checks++;
        assert ((bus.RegWre && bus.MemWr) === 1'b0) else begin
            failures++;
            $error("FAIL %s_excl observed RegWre=%b MemWr=%b expected not both", tag, bus.RegWre, bus.MemWr);
        end
    endtask

    // Runs one instruction from its IF; abort_at>=0 pulses reset right after checking that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string nm, input int abort_at);
        int kd;
        int n;
        kd = kind_of(o, f);
        n  = ins_len(kd);
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                bus.op = o; bus.funct = f;
            end else if (k >= 2) begin
                bus.op = 6'($urandom); bus.funct = 6'($urandom);
            end
            if (kd == K_BEQ || kd == K_BNE) bus.zero = z;
            else                            bus.zero = 1'($urandom);
            #1;
            check($sformatf("%s_c%0d", nm, k), model(o, f, z, k));
            if (k == abort_at) begin
                #2;
                Reset = 1'b0;
                #1;
                check($sformatf("%s_abort", nm), '0);
                @(posedge CLK);
                #1;
                check($sformatf("%s_abort_hold", nm), '0);
                @(negedge CLK);
                Reset = 1'b1;
                return;
            end
            @(negedge CLK);
        end
    endtask

    logic [5:0] dops [11];
    logic [5:0] dfun [11];
    logic       dz   [11];
    logic [5:0] lops [15];
    logic [5:0] lfun [15];

    initial begin
        // Directed: add, beq z=1, beq z=0, bne z=0, lw, sw, ori, slti, sltu, jal, op 111110.
        dops[0] = 6'b000000; dfun[0] = 6'b100000; dz[0] = 1'b0;
        dops[1] = 6'b000100; dfun[1] = 6'b000000; dz[1] = 1'b1;
        dops[2] = 6'b000100; dfun[2] = 6'b000000; dz[2] = 1'b0;
        dops[3] = 6'b000101; dfun[3] = 6'b000000; dz[3] = 1'b0;
        dops[4] = 6'b100011; dfun[4] = 6'b000000; dz[4] = 1'b0;
        dops[5] = 6'b101011; dfun[5] = 6'b000000; dz[5] = 1'b0;
        dops[6] = 6'b001101; dfun[6] = 6'b000000; dz[6] = 1'b0;
        dops[7] = 6'b001010; dfun[7] = 6'b000000; dz[7] = 1'b0;
        dops[8] = 6'b000000; dfun[8] = 6'b101011; dz[8] = 1'b0;
        dops[9] = 6'b000011; dfun[9] = 6'b000000; dz[9] = 1'b0;
        dops[10] = 6'b111110; dfun[10] = 6'b000000; dz[10] = 1'b0;

        lops[0] = 6'b000000; lfun[0] = 6'b100000;
        lops[1] = 6'b000000; lfun[1] = 6'b100010;
        lops[2] = 6'b000000; lfun[2] = 6'b100100;
        lops[3] = 6'b000000; lfun[3] = 6'b100101;
        lops[4] = 6'b000000; lfun[4] = 6'b101010;
        lops[5] = 6'b000000; lfun[5] = 6'b101011;
        lops[6] = 6'b001000; lops[7] = 6'b001101; lops[8] = 6'b001010;
        lops[9] = 6'b100011; lops[10] = 6'b101011; lops[11] = 6'b000100;
        lops[12] = 6'b000101; lops[13] = 6'b000010; lops[14] = 6'b000011;
        for (int i = 6; i < 15; i++) lfun[i] = 6'b000000;

        Reset = 1'b0;
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("reset", '0);
        @(negedge CLK);
        Reset = 1'b1;

        for (int i = 0; i < 11; i++)
            run_instr(dops[i], dfun[i], dz[i], $sformatf("dir%0d", i), -1);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] o;
            logic [5:0] f;
            int         idx;
            if ($urandom_range(0, 3) == 0) begin
                o = 6'($urandom);
                f = 6'($urandom);
                if (o == 6'b111111) o = 6'b111110;
            end else begin
                idx = $urandom_range(0, 14);
                o = lops[idx];
                f = (o == 6'b000000) ? lfun[idx] : 6'($urandom);
            end
            run_instr(o, f, 1'($urandom), $sformatf("rnd%0d", i), -1);
        end

        run_instr(6'b111111, 6'b000000, 1'b0, "halt", -1);
        Reset = 1'b0;
        #1;
        check("halt_reset", '0);
        @(negedge CLK);
        Reset = 1'b1;

        run_instr(6'b101011, 6'b000000, 1'b0, "sw_abort", 3);
        run_instr(6'b000000, 6'b100000, 1'b0, "after_abort", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
